mem_bus_arbiter: RTL

- Shares one single-port unified 16-bit word-addressed memory between two requesters: instruction fetch (IF) and data access (DM, for LW/SW).
- Sits between the multicycle core's fetch/MEM stages and the memory.
- Registered req/gnt/valid handshake; tolerates variable memory latency via mem_ack; aborts hung accesses with a wait-state timeout.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/arb_wait_ctr.sv | 42 ++++
 rtl/mem_bus_arbiter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the IF/DM memory bus arbiter.
// Holds the arbiter state enum, owner encoding and default timeout.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

    localparam int TIMEOUT_DEF = 255;

    function automatic int ctr_width(input int t);
        return (t < 1) ? 1 : $clog2(t + 1);
    endfunction

endpackage

// File: rtl/arb_wait_ctr.sv
// arb_wait_ctr: saturating wait-state counter with clear, enable and a
// compare flag that is high when the next increment reaches TIMEOUT.
module arb_wait_ctr
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic hit
);

    localparam int W = ctr_width(TIMEOUT);
    localparam logic [W-1:0] CNT_MAX = '1;
    localparam logic [W-1:0] LAST    = W'(TIMEOUT - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A zero TIMEOUT disables the abort path entirely.
    assign hit = (TIMEOUT != 0) && (cnt_q == LAST);

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one single-port memory between fetch and data.
// Define MEM_ARB_RR_EN for round-robin tie breaking instead of DM priority.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_valid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    arb_state_e state_q, state_d;

    logic owner_q, owner_d;
    logic err_flag_q, err_flag_d;
    logic if_gnt_q, if_gnt_d;
    logic dm_gnt_q, dm_gnt_d;
    logic if_valid_q, if_valid_d;
    logic dm_valid_q, dm_valid_d;
    logic if_err_q, if_err_d;
    logic dm_err_q, dm_err_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic mem_req_q, mem_req_d;
    logic mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic win;
    logic ctr_en;
    logic ctr_clr;
    logic tmo_hit;

`ifdef MEM_ARB_RR_EN
    logic last_owner_q, last_owner_d;

    // On a tie the requester that did not own the last access wins.
    always_comb begin
        if (if_req && dm_req) begin
            win = ~last_owner_q;
        end else begin
            win = dm_req ? OWN_DM : OWN_IF;
        end
    end

    always_comb begin
        last_owner_d = last_owner_q;
        if (state_q == RESP) begin
            last_owner_d = owner_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_owner_q <= OWN_IF;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end
`else
    // DM wins ties: it belongs to the instruction already in flight.
    assign win = dm_req ? OWN_DM : OWN_IF;
`endif

    assign ctr_en  = (state_q == BUS) && !mem_ack;
    assign ctr_clr = (state_q == RESP);

    arb_wait_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_ctr (
        .clk   (clk),
        .reset (reset),
        .clr   (ctr_clr),
        .en    (ctr_en),
        .hit   (tmo_hit)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        err_flag_d  = err_flag_q;
        if_gnt_d    = 1'b0;
        dm_gnt_d    = 1'b0;
        if_valid_d  = 1'b0;
        dm_valid_d  = 1'b0;
        if_err_d    = 1'b0;
        dm_err_d    = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        unique case (state_q)
            IDLE: begin
                if (if_req || dm_req) begin
                    owner_d     = win;
                    if_gnt_d    = (win == OWN_IF);
                    dm_gnt_d    = (win == OWN_DM);
                    mem_req_d   = 1'b1;
                    mem_we_d    = (win == OWN_DM) && dm_we;
                    mem_addr_d  = (win == OWN_DM) ? dm_addr : if_addr;
                    mem_wdata_d = (win == OWN_DM) ? dm_wdata : '0;
                    state_d     = BUS;
                end
            end
            BUS: begin
                if (mem_ack) begin
                    if (!mem_we_q) begin
                        if (owner_q == OWN_DM) begin
                            dm_rdata_d = mem_rdata;
                        end else begin
                            if_rdata_d = mem_rdata;
                        end
                    end
                    mem_req_d = 1'b0;
                    state_d   = RESP;
                end else if (tmo_hit) begin
                    mem_req_d  = 1'b0;
                    err_flag_d = 1'b1;
                    state_d    = RESP;
                end
            end
            RESP: begin
                if_valid_d = (owner_q == OWN_IF);
                dm_valid_d = (owner_q == OWN_DM);
                if_err_d   = err_flag_q && (owner_q == OWN_IF);
                dm_err_d   = err_flag_q && (owner_q == OWN_DM);
                err_flag_d = 1'b0;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            err_flag_q  <= 1'b0;
            if_gnt_q    <= 1'b0;
            dm_gnt_q    <= 1'b0;
            if_valid_q  <= 1'b0;
            dm_valid_q  <= 1'b0;
            if_err_q    <= 1'b0;
            dm_err_q    <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            err_flag_q  <= err_flag_d;
            if_gnt_q    <= if_gnt_d;
            dm_gnt_q    <= dm_gnt_d;
            if_valid_q  <= if_valid_d;
            dm_valid_q  <= dm_valid_d;
            if_err_q    <= if_err_d;
            dm_err_q    <= dm_err_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign if_gnt    = if_gnt_q;
    assign dm_gnt    = dm_gnt_q;
    assign if_valid  = if_valid_q;
    assign dm_valid  = dm_valid_q;
    assign if_err    = if_err_q;
    assign dm_err    = dm_err_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q != IDLE);
    assign owner     = owner_q;

endmodule
